reg_scoreboard: RTL

- Per-register pending-write scoreboard that decides when ID may issue.
- Generalises the single-stage load-use check to any number of in-flight long-latency producers (loads, mul/div).
- Sits beside the ID stage. It is updated on each ID->EXE transfer and on each WB retirement, and drives ID's ready_go.
- Also handles pipeline flush and saturation of per-register counters.

---
 rtl/reg_scoreboard_pkg.sv | 26 ++
 rtl/reg_scoreboard_sb_counter.sv | 47 ++++
 rtl/reg_scoreboard.sv | 127 ++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the pending-write scoreboard: default geometry,
// ID->scoreboard and WB->scoreboard bus widths, and the counter-maximum helper.
// SB_WB_BYPASS_EN (optional macro) lets a retiring last write release dependants in the same cycle.
package reg_scoreboard_pkg;

    // Default geometry: 32 architectural registers, 5-bit addresses, 2-bit counters.
    localparam int SB_NREG = 32;
    localparam int SB_AW   = 5;
    localparam int SB_CW   = 2;

    // ID_to_SB bus: {valid, rs_addr, rs_en, rt_addr, rt_en, dest_addr, dest_long, fire}
    function automatic int id_to_sb_bus_wd(input int aw);
        return 3 * aw + 5;
    endfunction

    // WB_to_SB bus: {valid, dest_addr, long}
    function automatic int wb_to_sb_bus_wd(input int aw);
        return aw + 2;
    endfunction

    // Largest value a CW-bit pending counter can hold (all ones).
    function automatic int sb_cnt_max(input int cw);
        return (1 << cw) - 1;
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Saturating CW-bit up/down pending-write counter for one architectural register.
// Ports: clk, reset (async active-high), inc, dec, clr (clr wins) -> cnt, err (one-cycle illegal-update pulse).
// inc+dec together cancel; inc at full or dec at zero holds the count and raises err.
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CW = SB_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          err
);

    localparam logic [CW-1:0] CNT_MAX = CW'(sb_cnt_max(CW));

    logic [CW-1:0] cnt_q;
    logic          up;
    logic          down;
    logic          full;
    logic          zero;

    assign up   = inc & ~dec;
    assign down = dec & ~inc;
    assign full = (cnt_q == CNT_MAX);
    assign zero = (cnt_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (up && !full) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (down && !zero) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // A flush clears everything, so an update that would have been illegal is moot.
    assign err = ~clr & ((up & full) | (down & zero));
    assign cnt = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard that gates ID issue against in-flight long-latency writes.
// Ports: ID request/fire bus in, WB retire bus in, flush in -> id_ready_go (combinational), sb_busy, sb_err (sticky).
// Optional macro SB_WB_BYPASS_EN: a retiring last outstanding write does not stall its readers that cycle.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG = SB_NREG,
    parameter int AW   = SB_AW,
    parameter int CW   = SB_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs_addr,
    input  logic          id_rs_en,
    input  logic [AW-1:0] id_rt_addr,
    input  logic          id_rt_en,
    input  logic [AW-1:0] id_dest_addr,
    input  logic          id_dest_long,
    input  logic          id_fire,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_dest_addr,
    input  logic          wb_long,
    input  logic          flush,
    output logic          id_ready_go,
    output logic          sb_busy,
    output logic          sb_err
);

    localparam int ID_BUS_WD = id_to_sb_bus_wd(AW);
    localparam int WB_BUS_WD = wb_to_sb_bus_wd(AW);
    localparam logic [CW-1:0] CNT_MAX = CW'(sb_cnt_max(CW));

    // Packed views of the two incoming pipeline buses.
    logic [ID_BUS_WD-1:0] id_to_sb_bus;
    logic [WB_BUS_WD-1:0] wb_to_sb_bus;

    assign id_to_sb_bus = {id_valid, id_rs_addr, id_rs_en, id_rt_addr, id_rt_en,
                           id_dest_addr, id_dest_long, id_fire};
    assign wb_to_sb_bus = {wb_valid, wb_dest_addr, wb_long};

    logic          b_valid;
    logic [AW-1:0] b_rs;
    logic          b_rs_en;
    logic [AW-1:0] b_rt;
    logic          b_rt_en;
    logic [AW-1:0] b_dest;
    logic          b_dest_long;
    logic          b_fire;
    logic          b_wb_valid;
    logic [AW-1:0] b_wb_dest;
    logic          b_wb_long;

    assign {b_valid, b_rs, b_rs_en, b_rt, b_rt_en, b_dest, b_dest_long, b_fire} = id_to_sb_bus;
    assign {b_wb_valid, b_wb_dest, b_wb_long} = wb_to_sb_bus;

    // Register 0 is hardwired zero and never tracked.
    logic inc_req;
    logic dec_req;

    assign inc_req = b_fire & b_dest_long & (b_dest != '0);
    assign dec_req = b_wb_valid & b_wb_long & (b_wb_dest != '0);

    logic [CW-1:0] cnt [NREG];
    logic [NREG-1:0] err_vec;

    assign cnt[0]     = '0;
    assign err_vec[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        sb_counter #(.CW(CW)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc_req & (b_dest == AW'(i))),
            .dec   (dec_req & (b_wb_dest == AW'(i))),
            .clr   (flush),
            .cnt   (cnt[i]),
            .err   (err_vec[i])
        );
    end

    // Pending test for a source operand.
    logic rs_pend;
    logic rt_pend;

`ifdef SB_WB_BYPASS_EN
    // The WB value is forwarded, so the final outstanding write retiring now is not a hazard.
    always_comb begin
        rs_pend = (cnt[b_rs] != '0)
                  & ~(dec_req & (b_wb_dest == b_rs) & (cnt[b_rs] == CW'(1)));
        rt_pend = (cnt[b_rt] != '0)
                  & ~(dec_req & (b_wb_dest == b_rt) & (cnt[b_rt] == CW'(1)));
    end
`else
    always_comb begin
        rs_pend = (cnt[b_rs] != '0);
        rt_pend = (cnt[b_rt] != '0);
    end
`endif

    logic haz_a;
    logic haz_b;
    logic sat;

    assign haz_a = b_rs_en & (b_rs != '0) & rs_pend;
    assign haz_b = b_rt_en & (b_rt != '0) & rt_pend;
    // Holding issue at a full counter keeps increments from ever overflowing.
    assign sat   = b_dest_long & (b_dest != '0) & (cnt[b_dest] == CNT_MAX);

    assign id_ready_go = ~(b_valid & (haz_a | haz_b | sat));

    always_comb begin
        sb_busy = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            sb_busy = sb_busy | (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_err <= 1'b0;
        end else if (|err_vec) begin
            sb_err <= 1'b1;
        end
    end

endmodule
